// File: rtl/ga_pkg.sv
// ============================================================================
// Module   : ga_pkg
// Purpose  : Shared Gate Array types and constants for the video path and the
//            register write decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ga_pkg;

    localparam logic [1:0] GA_MODE0 = 2'd0;
    localparam logic [1:0] GA_MODE1 = 2'd1;
    localparam logic [1:0] GA_MODE2 = 2'd2;
    localparam logic [1:0] GA_MODE3 = 2'd3;

    typedef logic [3:0] pen_t;
    typedef logic [4:0] hw_colour_t;

    localparam hw_colour_t GA_BORDER_RESET = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/pen_decode.sv
// ============================================================================
// Module   : pen_decode
// Purpose  : Extracts the pen of the current pixel from a video byte.
//            Optional macro PIXEL_MODE3_EN enables the 4-pen mode 3 decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pen_decode
    import ga_pkg::*;
(
    input  logic [7:0] pix_byte,
    input  logic [1:0] mode,
    input  logic [2:0] phase,
    output pen_t       pen
);

    logic [2:0] w_idx_wide;
    logic [2:0] w_idx_med;

    // Pixel index within the byte for 4-cycle and 2-cycle pixel modes
    assign w_idx_wide = {2'b00, phase[2]};
    assign w_idx_med  = {1'b0, phase[2:1]};

    always_comb begin
        pen = '0;
        case (mode)
            GA_MODE2: pen = {3'b000, pix_byte[3'd7 - phase]};
            GA_MODE1: pen = {2'b00, pix_byte[3'd3 - w_idx_med],
                             pix_byte[3'd7 - w_idx_med]};
`ifdef PIXEL_MODE3_EN
            GA_MODE3: pen = {2'b00, pix_byte[3'd3 - w_idx_wide],
                             pix_byte[3'd7 - w_idx_wide]};
`endif
            default:  pen = {pix_byte[3'd1 - w_idx_wide], pix_byte[3'd5 - w_idx_wide],
                             pix_byte[3'd3 - w_idx_wide], pix_byte[3'd7 - w_idx_wide]};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pixel_serializer.sv
// ============================================================================
// Module   : pixel_serializer
// Purpose  : Splits 16-bit video words into pixels, resolves pens through the
//            ink planes and outputs border outside the display / on underrun.
//            Optional macro PIXEL_MODE3_EN (handled in pen_decode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_serializer
    import ga_pkg::*;
(
    input  logic        CLK_n,
    input  logic        RESET,
    input  logic        PIX_LOAD,
    input  logic [15:0] VDATA,
    input  logic        DISPEN,
    input  logic        HSYNC,
    input  logic [1:0]  MODE,
    input  logic [4:0]  BORDER,
    input  logic [15:0] INKR0,
    input  logic [15:0] INKR1,
    input  logic [15:0] INKR2,
    input  logic [15:0] INKR3,
    input  logic [15:0] INKR4,
    output logic [4:0]  COLOUR
);

    logic [15:0] r_word;
    logic        r_disp;
    logic [3:0]  r_phase;
    logic        r_underrun;
    logic [1:0]  r_mode;
    logic [1:0]  r_mode_pend;
    logic        r_hsync_d;
    hw_colour_t  r_colour;

    logic [7:0]  w_byte;
    pen_t        w_pen;
    hw_colour_t  w_colour;

    assign w_byte = r_phase[3] ? r_word[7:0] : r_word[15:8];

    pen_decode u_pen_decode (
        .pix_byte (w_byte),
        .mode     (r_mode),
        .phase    (r_phase[2:0]),
        .pen      (w_pen)
    );

    always_comb begin
        w_colour = BORDER;
        if (r_disp && !r_underrun) begin
            w_colour = {INKR4[w_pen], INKR3[w_pen], INKR2[w_pen],
                        INKR1[w_pen], INKR0[w_pen]};
        end
    end

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            r_word      <= '0;
            r_disp      <= 1'b0;
            r_phase     <= 4'd15;
            r_underrun  <= 1'b1;
            r_mode      <= GA_MODE0;
            r_mode_pend <= GA_MODE0;
            r_hsync_d   <= 1'b0;
            r_colour    <= '0;
        end else begin
            r_hsync_d <= HSYNC;
            // Pending mode only moves to the word mode at a load, so a word never splits
            if (HSYNC && !r_hsync_d) begin
                r_mode_pend <= MODE;
            end
            if (PIX_LOAD) begin
                r_word     <= VDATA;
                r_disp     <= DISPEN;
                r_mode     <= r_mode_pend;
                r_phase    <= 4'd0;
                r_underrun <= 1'b0;
            end else if (r_phase == 4'd15) begin
                r_underrun <= 1'b1;
            end else begin
                r_phase <= r_phase + 4'd1;
            end
            r_colour <= w_colour;
        end
    end

    assign COLOUR = r_colour;

endmodule

`default_nettype wire

// File: tb/tb_pixel_serializer.sv
// ============================================================================
// Module   : tb_pixel_serializer
// Purpose  : Directed, table-driven self-checking bench for pixel_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_serializer;

    logic        CLK_n = 1'b0;
    logic        RESET;
    logic        PIX_LOAD;
    logic [15:0] VDATA;
    logic        DISPEN;
    logic        HSYNC;
    logic [1:0]  MODE;
    logic [4:0]  BORDER;
    logic [15:0] inkr [0:4];
    logic [4:0]  COLOUR;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]        mode;
        logic [15:0]       vdata;
        logic              dispen;
        logic [4:0]        border;
        int                pa;
        logic [4:0]        ca;
        int                pb;
        logic [4:0]        cb;
        logic [0:15][4:0]  exp;
    } vec_t;

    vec_t tbl [0:3];
    logic [0:15][4:0] exp_m0;

    pixel_serializer dut (
        .CLK_n    (CLK_n),
        .RESET    (RESET),
        .PIX_LOAD (PIX_LOAD),
        .VDATA    (VDATA),
        .DISPEN   (DISPEN),
        .HSYNC    (HSYNC),
        .MODE     (MODE),
        .BORDER   (BORDER),
        .INKR0    (inkr[0]),
        .INKR1    (inkr[1]),
        .INKR2    (inkr[2]),
        .INKR3    (inkr[3]),
        .INKR4    (inkr[4]),
        .COLOUR   (COLOUR)
    );

    always #5 CLK_n = ~CLK_n;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: COLOUR=%h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inks();
        for (int k = 0; k < 5; k++) inkr[k] = 16'h0000;
    endtask

    task automatic set_ink(input int p, input logic [4:0] c);
        for (int k = 0; k < 5; k++) inkr[k][p] = c[k];
    endtask

    task automatic tick();
        @(posedge CLK_n);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        MODE  = m;
        HSYNC = 1'b1;
        tick();
        HSYNC = 1'b0;
        tick();
    endtask

    task automatic load(input logic [15:0] d, input logic de);
        VDATA    = d;
        DISPEN   = de;
        PIX_LOAD = 1'b1;
        tick();
        PIX_LOAD = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; PIX_LOAD = 1'b0; VDATA = '0; DISPEN = 1'b0;
        HSYNC = 1'b0; MODE = 2'd0; BORDER = 5'h10;
        clear_inks();

        tbl[0] = '{mode: 2'd2, vdata: 16'hA50F, dispen: 1'b1, border: 5'h10,
                   pa: 1, ca: 5'h14, pb: 0, cb: 5'h00,
                   exp: {5'h14, 5'h00, 5'h14, 5'h00, 5'h00, 5'h14, 5'h00, 5'h14,
                         5'h00, 5'h00, 5'h00, 5'h00, 5'h14, 5'h14, 5'h14, 5'h14}};
        tbl[1] = '{mode: 2'd1, vdata: 16'h8800, dispen: 1'b1, border: 5'h10,
                   pa: 3, ca: 5'h07, pb: 0, cb: 5'h01,
                   exp: {5'h07, 5'h07, {14{5'h01}}}};
        tbl[2] = '{mode: 2'd0, vdata: 16'h8002, dispen: 1'b1, border: 5'h10,
                   pa: 1, ca: 5'h0A, pb: 8, cb: 5'h1F,
                   exp: {{4{5'h0A}}, {4{5'h00}}, {4{5'h1F}}, {4{5'h00}}}};
        tbl[3] = '{mode: 2'd2, vdata: 16'hFFFF, dispen: 1'b0, border: 5'h10,
                   pa: 1, ca: 5'h14, pb: 0, cb: 5'h00,
                   exp: {16{5'h10}}};
        exp_m0 = {{4{5'h14}}, {4{5'h00}}, {4{5'h1F}}, {4{5'h00}}};

        repeat (3) @(posedge CLK_n);
        #1;
        chk("reset_colour", COLOUR, 5'h00);
        RESET = 1'b0;
        tick();
        chk("post_reset_border", COLOUR, 5'h10);

        for (int v = 0; v < 4; v++) begin
            clear_inks();
            set_ink(tbl[v].pa, tbl[v].ca);
            set_ink(tbl[v].pb, tbl[v].cb);
            BORDER = tbl[v].border;
            set_mode(tbl[v].mode);
            load(tbl[v].vdata, tbl[v].dispen);
            for (int k = 0; k < 16; k++) begin
                tick();
                chk($sformatf("vec%0d_px%0d", v, k), COLOUR, tbl[v].exp[k]);
            end
        end

        // Underrun after the border word: live BORDER change shows one cycle later
        BORDER = 5'h04;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("underrun_border_%0d", k), COLOUR, 5'h04);
        end

        // Mode change mid-word: current word keeps mode 2, next word uses mode 0
        clear_inks();
        set_ink(1, 5'h14);
        set_ink(8, 5'h1F);
        BORDER = 5'h10;
        set_mode(2'd2);
        load(16'hA50F, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            if (k == 2) begin MODE = 2'd0; HSYNC = 1'b1; end
            if (k == 3) HSYNC = 1'b0;
            chk($sformatf("modechg_old_px%0d", k), COLOUR, tbl[0].exp[k]);
        end
        load(16'h8002, 1'b1);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("modechg_new_px%0d", k), COLOUR, exp_m0[k]);
        end
        tick();
        chk("underrun_after_display", COLOUR, 5'h10);

        // HSYNC edge in the same cycle as PIX_LOAD: word takes old pending mode (0)
        MODE = 2'd2;
        HSYNC = 1'b1;
        load(16'h8000, 1'b1);
        HSYNC = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("sameedge_px%0d", k), COLOUR, (k < 4) ? 5'h14 : 5'h00);
        end
        tick();
        load(16'h4000, 1'b1);
        tick();
        chk("pend_applied_px0", COLOUR, 5'h00);
        tick();
        chk("pend_applied_px1", COLOUR, 5'h14);

        // Reset mid-word
        load(16'hA50F, 1'b1);
        tick();
        chk("rst_mid_px0", COLOUR, 5'h14);
        tick();
        chk("rst_mid_px1", COLOUR, 5'h00);
        RESET = 1'b1;
        tick();
        chk("rst_mid_zero", COLOUR, 5'h00);
        RESET = 1'b0;
        tick();
        chk("rst_mid_border", COLOUR, 5'h10);

        // RESET wins over PIX_LOAD
        RESET = 1'b1;
        load(16'hFFFF, 1'b1);
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("rst_wins_%0d", k), COLOUR, 5'h10);
        end

        // Mode 3 pixel 0 of 0x0A: pen 2 with mode 3 enabled, else mode-0 pen 10
        clear_inks();
        set_ink(2, 5'h02);
        set_ink(10, 5'h0A);
        set_mode(2'd3);
        load(16'h0A00, 1'b1);
        tick();
`ifdef PIXEL_MODE3_EN
        chk("mode3_px0", COLOUR, 5'h02);
`else
        chk("mode3_px0", COLOUR, 5'h0A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pixel_serializer.md
# pixel_serializer

Video-side reader for the Gate Array palette and mode state. Takes each 16-bit video word fetched from RAM, splits it into pixels according to the latched screen mode, decodes pixel pens, and resolves pens to 5-bit hardware colours through the ink registers. Outside the display area it outputs the border colour. It sits between the RAM fetch sequencer and the colour DAC driver, and consumes the outputs of the register write decoder.

## Interface
- No parameters.
- CLK_n  in  1  16 MHz master clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- PIX_LOAD  in  1  one-cycle strobe: VDATA and DISPEN are valid; start a new 16-cycle word.
- VDATA  in  16  video word; [15:8] is displayed first, [7:0] second.
- DISPEN  in  1  display enable for this word; sampled only with PIX_LOAD.
- HSYNC  in  1  horizontal sync from the CRTC.
- MODE  in  2  mode register value.
- BORDER  in  5  border hardware colour.
- INKR0..INKR4  in  16 each  ink bit-planes; bit p of INKRk is bit k of pen p's colour.
- COLOUR  out  5  hardware colour of the current pixel, registered.

## Operation
- Word latch: on PIX_LOAD, capture VDATA into word_q, DISPEN into disp_q, mode_pend into mode_q, and clear phase to 0.
- Phase: 4-bit counter, +1 per cycle after a load. At 15 with no new PIX_LOAD it holds at 15 and sets underrun; underrun forces border output until the next PIX_LOAD. A PIX_LOAD at any phase restarts at 0, and the remainder of the old word is discarded.
- Byte select: phase[3]=0 selects word_q[15:8], 1 selects word_q[7:0].
- Pixel index and pen, with b the selected byte:
  - Mode 2, index = phase[2:0]: pen = b[7-i].
  - Mode 1, index = phase[2:1]: pen = {b[3-i], b[7-i]}.
  - Mode 0, index = phase[2]: pen = {b[1-i], b[5-i], b[3-i], b[7-i]}.
  - Mode 3 (see Configuration): pen = {b[3-i], b[7-i]} with index = phase[2].
- Colour: if disp_q=0 or underrun, COLOUR uses BORDER. Otherwise COLOUR = {INKR4[pen], INKR3[pen], INKR2[pen], INKR1[pen], INKR0[pen]}.
- BORDER and INKRx are read live: a write takes effect on the next registered pixel, including mid-word.
- Mode latching: mode_pend loads MODE on the HSYNC rising edge (HSYNC=1 and hsync_d=0). It reaches mode_q only at the next PIX_LOAD, so a word is never split across modes. If the HSYNC edge and PIX_LOAD fall in the same cycle, the word gets the old mode_pend.

## Timing
- PIX_LOAD asserted in cycle N: pixel phase 0 appears on COLOUR in cycle N+2. Phase k appears in cycle N+2+k.
- Pixel widths are 1, 2 and 4 cycles for modes 2, 1 and 0/3; all modes use 16 cycles per word.
- Reset values: COLOUR=0, word_q=0, disp_q=0, phase=15, underrun=1, mode_q=0, mode_pend=0, hsync_d=0.
- RESET wins over PIX_LOAD in the same cycle.
- After reset is released, COLOUR shows BORDER until 2 cycles after the first PIX_LOAD.
- RESET mid-word: COLOUR=0 in the following cycle and the word is abandoned.

## Configuration
- PIXEL_MODE3_EN
  - Defined: mode 3 decodes as described above (160-wide, 4 pens).
  - Undefined: MODE value 3 decodes exactly as mode 0.

## Structure
- Shared package ga_pkg holds:
  - Mode constants GA_MODE0..GA_MODE3.
  - Typedefs for the 4-bit pen and the 5-bit hardware colour.
  - The border-at-reset constant 5'b10000, shared with the register decoder.
- One combinational sub-module, pen_decode: inputs byte, mode, phase[2:0]; output 4-bit pen. It carries the PIXEL_MODE3_EN guard.
- Ink lookup, phase counter, latches and output register stay in pixel_serializer.

## Test plan
- Mode 2, DISPEN=1, pen1 set to colour 5'h14, pen0 set to 5'h00, VDATA=16'hA50F: COLOUR from N+2 is 14,0,14,0,0,14,0,14,0,0,0,0,14,14,14,14.
- Mode 1, VDATA=16'h8800, pen3 set to 5'h07: COLOUR is 07 for 2 cycles, then pen0 for 6 cycles, then pen0 for 8 cycles (low byte).
- Mode 0, VDATA=16'h8002, pen1 set to 5'h0A and pen8 set to 5'h1F: COLOUR is 0A for 4 cycles, pen0 for 4, 1F for 4, pen0 for 4.
- Border and underrun: DISPEN=0, BORDER=5'h10 gives 16 cycles of 10. Then withhold PIX_LOAD and change BORDER to 5'h04: COLOUR goes to 04 one cycle later and holds.
- Mode change: MODE written 2→0 with an HSYNC edge mid-word; the current word stays mode 2 and the next PIX_LOAD word decodes as mode 0. Pulse RESET mid-word: COLOUR=0 the next cycle.
- Mode 3, VDATA=16'h0A00, pixel 0: pen 2 with PIXEL_MODE3_EN defined, pen 10 without it.
